// File: rtl/fetch_refill_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_refill_if : miss/refill handshake between fetch, refill, memory |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface fetch_refill_if #(
  parameter int addressSize       = 64,
  parameter int memBusWidth       = 64,
  parameter int cachelineSizeBits = 256
);
  logic                           isCacheMiss_i;
  logic [0:addressSize-1]         missAddress_i;
  logic                           memReadReq_o;
  logic [0:addressSize-1]         memReadAddress_o;
  logic                           memReadAck_i;
  logic                           memReadDataValid_i;
  logic [0:memBusWidth-1]         memReadData_i;
  logic [0:addressSize-1]         newAddress_o;
  logic [0:cachelineSizeBits-1]   newCacheline_o;
  logic                           cacheUpdateEnable_o;
  logic                           busy_o;
  logic [0:15]                    refillCount_o;

  modport master (
    input  isCacheMiss_i, missAddress_i, memReadAck_i, memReadDataValid_i, memReadData_i,
    output memReadReq_o, memReadAddress_o, newAddress_o, newCacheline_o,
           cacheUpdateEnable_o, busy_o, refillCount_o
  );

  modport slave (
    output isCacheMiss_i, missAddress_i, memReadAck_i, memReadDataValid_i, memReadData_i,
    input  memReadReq_o, memReadAddress_o, newAddress_o, newCacheline_o,
           cacheUpdateEnable_o, busy_o, refillCount_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_refill_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_refill_controller : sequences I-cache miss refills from memory |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_refill_controller #(
  parameter int offsetSize        = 5,
  parameter int indexSize         = 8,
  parameter int addressSize       = 64,
  parameter int cachelineSizeBits = (2**offsetSize)*8,
  parameter int memBusWidth       = 64,
  parameter int beatsPerLine      = cachelineSizeBits/memBusWidth
)(
  input wire logic       clock_i,
  input wire logic       reset_i,
  fetch_refill_if.master bus
);
  localparam int c_BEAT_W = (beatsPerLine > 1) ? $clog2(beatsPerLine) : 1;
  // Offset field is the least significant end of the address (rightmost bits).
  localparam logic [0:addressSize-1] c_ALIGN_MASK =
    {{(addressSize-offsetSize){1'b1}}, {offsetSize{1'b0}}};

  generate
    if (((cachelineSizeBits % memBusWidth) != 0) || ((offsetSize + indexSize) > addressSize)) begin : g_cfg_check
      $error("fetch_refill_controller: inconsistent geometry parameters");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_RECEIVE = 3'd2,
    S_UPDATE  = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t                       r_state;
  logic [c_BEAT_W-1:0]          r_beat;
  logic [0:addressSize-1]       r_addr;
  logic [0:cachelineSizeBits-1] r_line;
  logic                         r_req;
  logic [0:addressSize-1]       r_req_addr;
  logic [0:addressSize-1]       r_new_addr;
  logic [0:cachelineSizeBits-1] r_new_line;
  logic                         r_cue;
  logic                         r_busy;
  logic [0:15]                  r_refill_count;

  logic [0:addressSize-1]       w_aligned;
  logic [0:cachelineSizeBits-1] w_line_next;
  logic                         w_last_beat;

  assign w_aligned   = bus.missAddress_i & c_ALIGN_MASK;
  assign w_last_beat = (r_beat == c_BEAT_W'(beatsPerLine-1));

  always_comb begin
    w_line_next = r_line;
    for (int b = 0; b < beatsPerLine; b++) begin
      if (r_beat == c_BEAT_W'(b)) begin
        w_line_next[b*memBusWidth +: memBusWidth] = bus.memReadData_i;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state        <= S_IDLE;
      r_beat         <= '0;
      r_addr         <= '0;
      r_line         <= '0;
      r_req          <= 1'b0;
      r_req_addr     <= '0;
      r_new_addr     <= '0;
      r_new_line     <= '0;
      r_cue          <= 1'b0;
      r_busy         <= 1'b0;
      r_refill_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.isCacheMiss_i) begin
            r_addr     <= w_aligned;
            r_beat     <= '0;
            r_req      <= 1'b1;
            r_req_addr <= w_aligned;
            r_busy     <= 1'b1;
            r_state    <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (bus.memReadAck_i) begin
            r_req   <= 1'b0;
            r_state <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          if (bus.memReadDataValid_i) begin
            r_line <= w_line_next;
            r_beat <= r_beat + c_BEAT_W'(1);
            // Install outputs are loaded on the last beat so the strobe cycle presents them.
            if (w_last_beat) begin
              r_cue          <= 1'b1;
              r_new_addr     <= r_addr;
              r_new_line     <= w_line_next;
              r_refill_count <= r_refill_count + 16'd1;
              r_state        <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          r_cue   <= 1'b0;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cue   <= 1'b0;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.memReadReq_o        = r_req;
  assign bus.memReadAddress_o    = r_req_addr;
  assign bus.newAddress_o        = r_new_addr;
  assign bus.newCacheline_o      = r_new_line;
  assign bus.cacheUpdateEnable_o = r_cue;
  assign bus.busy_o              = r_busy;
  assign bus.refillCount_o       = r_refill_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_refill_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_refill_controller : vector table, directed and random refills|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_refill_controller;
  typedef logic [63:0] beats_t [4];
  typedef struct {
    logic [63:0] addr;
    logic [63:0] exp_addr;
    int          ack_dly;
    int          gap;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] exp_count = 16'd0;

  fetch_refill_if #(.addressSize(64), .memBusWidth(64), .cachelineSizeBits(256)) bus();

  fetch_refill_controller #(
    .offsetSize(5), .indexSize(8), .addressSize(64),
    .cachelineSizeBits(256), .memBusWidth(64), .beatsPerLine(4)
  ) dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary expected one");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full refill, checking every cycle against the timing rules.
  task automatic do_refill(input string nm, input logic [63:0] addr, input logic [63:0] exp_addr,
                           input int ack_dly, input int gap, input bit rnd_gap, input bit stray,
                           input bit hold, input beats_t d);
    logic [255:0] exp_line;
    int g;
    exp_line = {d[0], d[1], d[2], d[3]};
    chk({nm, " idle busy"}, 256'(bus.busy_o), 256'(0));
    bus.isCacheMiss_i = 1'b1;
    bus.missAddress_i = addr;
    tick();
    chk({nm, " req"}, 256'(bus.memReadReq_o), 256'(1));
    chk({nm, " req addr"}, 256'(bus.memReadAddress_o), 256'(exp_addr));
    chk({nm, " busy"}, 256'(bus.busy_o), 256'(1));
    bus.missAddress_i = {$urandom, $urandom};
    for (int i = 0; i < ack_dly; i++) begin
      bus.memReadDataValid_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.memReadData_i      = {$urandom, $urandom};
      tick();
      chk({nm, " req stall"}, 256'(bus.memReadReq_o), 256'(1));
      chk({nm, " addr stall"}, 256'(bus.memReadAddress_o), 256'(exp_addr));
    end
    bus.memReadAck_i       = 1'b1;
    bus.memReadDataValid_i = stray;
    bus.memReadData_i      = {$urandom, $urandom};
    tick();
    bus.memReadAck_i       = 1'b0;
    bus.memReadDataValid_i = 1'b0;
    chk({nm, " req drop"}, 256'(bus.memReadReq_o), 256'(0));
    chk({nm, " busy rx"}, 256'(bus.busy_o), 256'(1));
    for (int b = 0; b < 4; b++) begin
      g = rnd_gap ? $urandom_range(0, gap) : gap;
      for (int j = 0; j < g; j++) begin
        bus.memReadAck_i  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.memReadData_i = {$urandom, $urandom};
        tick();
        chk({nm, " no strobe gap"}, 256'(bus.cacheUpdateEnable_o), 256'(0));
      end
      bus.memReadAck_i       = 1'b0;
      bus.memReadDataValid_i = 1'b1;
      bus.memReadData_i      = d[b];
      tick();
      bus.memReadDataValid_i = 1'b0;
      if (b < 3) begin
        chk({nm, " no strobe beat"}, 256'(bus.cacheUpdateEnable_o), 256'(0));
      end else begin
        exp_count = exp_count + 16'd1;
        chk({nm, " strobe"}, 256'(bus.cacheUpdateEnable_o), 256'(1));
        chk({nm, " new addr"}, 256'(bus.newAddress_o), 256'(exp_addr));
        chk({nm, " line"}, 256'(bus.newCacheline_o), exp_line);
        chk({nm, " count"}, 256'(bus.refillCount_o), 256'(exp_count));
      end
    end
    if (!hold) bus.isCacheMiss_i = 1'b0;
    tick();
    chk({nm, " strobe one cycle"}, 256'(bus.cacheUpdateEnable_o), 256'(0));
    chk({nm, " busy drain"}, 256'(bus.busy_o), 256'(1));
    chk({nm, " line held"}, 256'(bus.newCacheline_o), exp_line);
    tick();
    chk({nm, " busy idle"}, 256'(bus.busy_o), 256'(0));
    chk({nm, " no req drain"}, 256'(bus.memReadReq_o), 256'(0));
    bus.isCacheMiss_i = 1'b0;
    tick();
    chk({nm, " no second req"}, 256'(bus.memReadReq_o), 256'(0));
    chk({nm, " count stable"}, 256'(bus.refillCount_o), 256'(exp_count));
  endtask

  task automatic rand_beats(output beats_t d);
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
  endtask

  initial begin
    vec_t   tbl [5];
    beats_t d;
    logic [63:0] a;

    tbl[0] = '{64'h0000_0000_0000_001F, 64'h0000_0000_0000_0000, 0, 0};
    tbl[1] = '{64'h0000_0000_0000_0020, 64'h0000_0000_0000_0020, 1, 0};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE0, 0, 1};
    tbl[3] = '{64'h8000_0000_0000_003F, 64'h8000_0000_0000_0020, 3, 2};
    tbl[4] = '{64'h1234_5678_9ABC_DEF7, 64'h1234_5678_9ABC_DEE0, 1, 0};

    bus.isCacheMiss_i      = 1'b0;
    bus.missAddress_i      = '0;
    bus.memReadAck_i       = 1'b0;
    bus.memReadDataValid_i = 1'b0;
    bus.memReadData_i      = '0;

    #2 rst_n = 1'b0;
    tick(); tick();
    chk("reset req", 256'(bus.memReadReq_o), 256'(0));
    chk("reset busy", 256'(bus.busy_o), 256'(0));
    chk("reset strobe", 256'(bus.cacheUpdateEnable_o), 256'(0));
    chk("reset count", 256'(bus.refillCount_o), 256'(0));
    chk("reset line", 256'(bus.newCacheline_o), 256'(0));
    rst_n = 1'b1;
    tick();

    d = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
          64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3};
    do_refill("basic", 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1220, 2, 0, 0, 0, 0, d);

    for (int i = 0; i < 5; i++) begin
      rand_beats(d);
      do_refill($sformatf("table%0d", i), tbl[i].addr, tbl[i].exp_addr, tbl[i].ack_dly, tbl[i].gap, 0, 0, 0, d);
    end

    rand_beats(d);
    do_refill("gapped", 64'h0000_0000_0000_4444, 64'h0000_0000_0000_4440, 3, 3, 0, 1, 0, d);
    rand_beats(d);
    do_refill("held miss", 64'h0000_0000_0000_5555, 64'h0000_0000_0000_5540, 0, 0, 0, 0, 1, d);

    for (int i = 0; i < 30; i++) begin
      a = {$urandom, $urandom};
      rand_beats(d);
      do_refill($sformatf("rand%0d", i), a, a - (a % 64'd32), $urandom_range(0, 4), 3, 1,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
    end

    // Reset in the middle of a refill, after two beats.
    bus.isCacheMiss_i = 1'b1;
    bus.missAddress_i = 64'h0000_0000_0000_7777;
    tick();
    bus.memReadAck_i = 1'b1;
    tick();
    bus.memReadAck_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.memReadDataValid_i = 1'b1;
      bus.memReadData_i      = {$urandom, $urandom};
      tick();
    end
    bus.memReadDataValid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_count = 16'd0;
    chk("midreset req", 256'(bus.memReadReq_o), 256'(0));
    chk("midreset req addr", 256'(bus.memReadAddress_o), 256'(0));
    chk("midreset new addr", 256'(bus.newAddress_o), 256'(0));
    chk("midreset line", 256'(bus.newCacheline_o), 256'(0));
    chk("midreset strobe", 256'(bus.cacheUpdateEnable_o), 256'(0));
    chk("midreset busy", 256'(bus.busy_o), 256'(0));
    chk("midreset count", 256'(bus.refillCount_o), 256'(0));
    bus.isCacheMiss_i = 1'b0;
    tick();
    chk("midreset no strobe", 256'(bus.cacheUpdateEnable_o), 256'(0));
    rst_n = 1'b1;
    tick();
    rand_beats(d);
    do_refill("after reset", 64'h0000_0000_0000_7777, 64'h0000_0000_0000_7760, 1, 0, 0, 0, 0, d);

    // Counter wrap: preload 0xFFFE completed refills, then two more (one with a long ack stall).
    force dut.r_refill_count = 16'hFFFE;
    tick();
    release dut.r_refill_count;
    tick();
    exp_count = 16'hFFFE;
    chk("preload count", 256'(bus.refillCount_o), 256'(exp_count));
    rand_beats(d);
    do_refill("stall20", 64'h0000_0000_0000_9ABC, 64'h0000_0000_0000_9AA0, 20, 0, 0, 0, 0, d);
    rand_beats(d);
    do_refill("wrap", 64'h0000_0000_0000_0040, 64'h0000_0000_0000_0040, 0, 0, 0, 0, 0, d);
    chk("wrapped to zero", 256'(bus.refillCount_o), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
